// File: rtl/cache_ctrl_wb_if.sv
// cache_ctrl_wb_if: CPU data port and word-wide RAM port of the write-back cache
interface cache_ctrl_wb_if #(
  parameter int ADDR_W = 32
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic stall;
  logic flush;
  logic flush_done;
  logic ram_cs;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic ram_ack;
  modport master (
    output req, we, addr, wdata, flush, ram_dout, ram_ack,
    input rdata, stall, flush_done, ram_cs, ram_we, ram_addr, ram_din
  );
  modport slave (
    input req, we, addr, wdata, flush, ram_dout, ram_ack,
    output rdata, stall, flush_done, ram_cs, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb: write-back, write-allocate 1/2-way LRU cache controller with burst RAM port and flush
module cache_ctrl_wb #(
  parameter int ADDR_W = 32,
  parameter int WORDS = 4,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input logic clk,
  input logic rst_n,
  cache_ctrl_wb_if.slave bus
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - OW - IW - 2;
  localparam int LW = $clog2(SETS * WAYS) + 1;
  localparam logic [LW-1:0] LAST_PTR = LW'(SETS * WAYS);
  typedef enum logic [2:0] {IDLE, WB, FILL, DONE, FL_SCAN, FL_WB} state_t;
  state_t state, state_d;
  logic [TW-1:0] tag_mem [WAYS][SETS];
  logic [31:0] data_mem [WAYS][SETS][WORDS];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [SETS-1:0] lru;
  logic [OW-1:0] beat;
  logic vic;
  logic [LW-1:0] fl_ptr;
  logic [TW-1:0] a_tag;
  logic [IW-1:0] a_idx;
  logic [OW-1:0] a_off;
  logic [1:0] hit_w;
  logic hit, hit_way, vic_sel, last, wr_st, fl_way, cur_way;
  logic [IW-1:0] fl_set, cur_set;
  assign {a_tag, a_idx, a_off} = bus.addr[ADDR_W-1:2];
  always_comb begin
    hit_w = '0;
    for (int i = 0; i < WAYS; i++) hit_w[i] = valid[a_idx][i] && tag_mem[i][a_idx] == a_tag;
  end
  assign hit = |hit_w;
  assign hit_way = hit_w[1];
  // first invalid way wins, otherwise the set's LRU way
  assign vic_sel = (WAYS == 2) && valid[a_idx][0] && (!valid[a_idx][WAYS-1] || lru[a_idx]);
  assign last = beat == OW'(WORDS - 1);
  assign fl_set = IW'(fl_ptr >> (WAYS - 1));
  assign fl_way = (WAYS == 2) && fl_ptr[0];
  assign cur_set = state == FL_WB ? fl_set : a_idx;
  assign cur_way = state == FL_WB ? fl_way : vic;
  assign wr_st = state == WB || state == FL_WB;
  assign bus.ram_cs = wr_st || state == FILL;
  assign bus.ram_we = wr_st;
  assign bus.ram_addr = wr_st ? {tag_mem[cur_way][cur_set], cur_set, beat, 2'b00} :
                        state == FILL ? {a_tag, a_idx, beat, 2'b00} : '0;
  assign bus.ram_din = wr_st ? data_mem[cur_way][cur_set][beat] : '0;
  assign bus.rdata = (state == IDLE && bus.req && !bus.we && hit) ? data_mem[hit_way][a_idx][a_off] : '0;
  assign bus.stall = rst_n && bus.req && !(state == IDLE && hit);
  assign bus.flush_done = state == FL_SCAN && fl_ptr == LAST_PTR;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = bus.req ? (hit ? IDLE : dirty[a_idx][vic_sel] ? WB : FILL) : bus.flush ? FL_SCAN : IDLE;
      WB: state_d = bus.ram_ack && last ? FILL : WB;
      FILL: state_d = bus.ram_ack && last ? DONE : FILL;
      DONE: state_d = IDLE;
      FL_SCAN: state_d = fl_ptr == LAST_PTR ? IDLE : dirty[fl_set][fl_way] ? FL_WB : FL_SCAN;
      FL_WB: state_d = bus.ram_ack && last ? FL_SCAN : FL_WB;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      vic <= 1'b0;
      fl_ptr <= '0;
      lru <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      if (bus.ram_cs && bus.ram_ack) beat <= beat + 1'b1;
      case (state)
        IDLE: if (bus.req && hit) begin
          lru[a_idx] <= !hit_way;
          if (bus.we) dirty[a_idx][hit_way] <= 1'b1;
        end else if (bus.req) begin
          // victim goes invalid before refill so an aborted burst never leaves a mixed line valid
          vic <= vic_sel;
          valid[a_idx][vic_sel] <= 1'b0;
        end
        DONE: begin
          valid[a_idx][vic] <= 1'b1;
          dirty[a_idx][vic] <= 1'b0;
          lru[a_idx] <= !vic;
        end
        FL_SCAN: fl_ptr <= fl_ptr == LAST_PTR ? '0 : dirty[fl_set][fl_way] ? fl_ptr : fl_ptr + 1'b1;
        FL_WB: if (bus.ram_ack && last) begin
          dirty[fl_set][fl_way] <= 1'b0;
          fl_ptr <= fl_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req && bus.we && hit) data_mem[hit_way][a_idx][a_off] <= bus.wdata;
    if (state == FILL && bus.ram_ack) data_mem[vic][a_idx][beat] <= bus.ram_dout;
    if (state == DONE) tag_mem[vic][a_idx] <= a_tag;
  end
endmodule
